// File: rtl/load_store_unit.sv
// Memory-stage load/store initiator for a word-addressed data memory without byte enables.
// Sub-word loads are extracted and extended here; sub-word stores become read-modify-write.
`timescale 1ns/1ps
module load_store_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_load,
  input  logic                  req_is_store,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_data,
  output logic                  resp_fault,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_write_data,
  input  logic [31:0]           mem_read_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STORE,
    S_RMW_RD,
    S_RMW_WR,
    S_RESP
  } state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            funct3_q;
  logic [31:0]           wdata_q;
  logic [31:0]           old_word_q;
  logic [31:0]           data_q;
  logic                  fault_q;

  logic accept;
  logic type_ok;
  logic funct3_ok;
  logic misaligned;
  logic req_fault;

  // Select the addressed lane of a fetched word and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  offset,
                                              input logic [2:0]  funct3);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] result;
    case (offset)
      2'd0:    lane_b = word[7:0];
      2'd1:    lane_b = word[15:8];
      2'd2:    lane_b = word[23:16];
      default: lane_b = word[31:24];
    endcase
    lane_h = offset[1] ? word[31:16] : word[15:0];
    case (funct3)
      3'b000:  result = {{24{lane_b[7]}}, lane_b};
      3'b001:  result = {{16{lane_h[15]}}, lane_h};
      3'b010:  result = word;
      3'b100:  result = {24'h0, lane_b};
      3'b101:  result = {16'h0, lane_h};
      default: result = 32'h0;
    endcase
    return result;
  endfunction

  // Replace the target byte/halfword lane of the old word, keeping every other bit.
  function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  offset,
                                              input logic [2:0]  funct3);
    logic [31:0] merged;
    merged = old_word;
    if (funct3[1:0] == 2'b00) begin
      case (offset)
        2'd0:    merged[7:0]   = wdata[7:0];
        2'd1:    merged[15:8]  = wdata[7:0];
        2'd2:    merged[23:16] = wdata[7:0];
        default: merged[31:24] = wdata[7:0];
      endcase
    end else if (offset[1]) begin
      merged[31:16] = wdata[15:0];
    end else begin
      merged[15:0] = wdata[15:0];
    end
    return merged;
  endfunction

  assign accept = req_valid && (state == S_IDLE);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    type_ok    = req_is_load ^ req_is_store;
    funct3_ok  = 1'b0;
    misaligned = 1'b0;
    if (req_is_load) begin
      funct3_ok = req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end else begin
      funct3_ok = req_funct3 inside {3'b000, 3'b001, 3'b010};
    end
    if (req_funct3[1:0] == 2'b01) begin
      misaligned = req_addr[0];
    end else if (req_funct3[1:0] == 2'b10) begin
      misaligned = (req_addr[1:0] != 2'b00);
    end
    req_fault = !type_ok || !funct3_ok || misaligned;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (req_fault)                    state_next = S_RESP;
          else if (req_is_load)             state_next = S_LOAD;
          else if (req_funct3 == 3'b010)    state_next = S_STORE;
          else                              state_next = S_RMW_RD;
        end
      end
      S_LOAD:   state_next = S_RESP;
      S_STORE:  state_next = S_RESP;
      S_RMW_RD: state_next = S_RMW_WR;
      S_RMW_WR: state_next = S_RESP;
      S_RESP:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // NOTE: the latched fields are reset as well, because they drive outputs that must read 0 after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q     <= '0;
      funct3_q   <= 3'b000;
      wdata_q    <= 32'h0;
      old_word_q <= 32'h0;
      data_q     <= 32'h0;
      fault_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            addr_q   <= req_addr;
            funct3_q <= req_funct3;
            wdata_q  <= req_wdata;
            fault_q  <= req_fault;
            data_q   <= 32'h0;
          end
        end
        S_LOAD:   data_q     <= load_extend(mem_read_data, addr_q[1:0], funct3_q);
        S_RMW_RD: old_word_q <= mem_read_data;
        default: ;
      endcase
    end
  end

  // The address is held from the latched request, so it cannot move while a strobe is high.
  assign mem_address = {addr_q[ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    req_ready      = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_write_data = 32'h0;
    resp_valid     = 1'b0;
    resp_data      = 32'h0;
    resp_fault     = 1'b0;
    case (state)
      S_IDLE:   req_ready = 1'b1;
      S_LOAD:   mem_read  = 1'b1;
      S_RMW_RD: mem_read  = 1'b1;
      S_STORE: begin
        mem_write      = 1'b1;
        mem_write_data = wdata_q;
      end
      S_RMW_WR: begin
        mem_write      = 1'b1;
        mem_write_data = store_merge(old_word_q, wdata_q, addr_q[1:0], funct3_q);
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_data  = data_q;
        resp_fault = fault_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a small word memory model, hand-computed expectations.
`timescale 1ns/1ps
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_load;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_fault;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic [31:0] mem [0:63];
  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_val;
  logic [31:0] last_wr_addr;

  int n_checks = 0;
  int n_fail   = 0;

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_is_load    (req_is_load),
    .req_is_store   (req_is_store),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .resp_fault     (resp_fault),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Poison value outside read cycles exposes any sampling of the bus when it is not driven.
  assign mem_read_data = mem_read ? mem[mem_address[7:2]] : 32'hDEAD_0BAD;

  always @(posedge clk) begin
    if (mem_write) mem[mem_address[7:2]] <= mem_write_data;
    else if (pl_en) mem[pl_idx] <= pl_val;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] val);
    @(negedge clk);
    pl_en  = 1'b1;
    pl_idx = idx;
    pl_val = val;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  task automatic run_req(input string tag, input logic ld, input logic st,
                         input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                         input int exp_lat, input logic [31:0] exp_data, input logic exp_fault,
                         input int exp_rd, input int exp_wr);
    int          lat = 0, rd = 0, wr = 0, first_rd = 0, first_wr = 0;
    logic        bad_strobe = 1'b0, ready_high = 1'b0, addr_seen = 1'b0, flt = 1'b0;
    logic [31:0] saddr = 32'h0, dat = 32'h0;
    @(negedge clk);
    check({tag, ".ready_before"}, {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_is_load = ld; req_is_store = st;
    req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1;
    // Junk inputs after accept must be ignored while busy.
    req_valid = 1'b0; req_is_load = 1'b1; req_is_store = 1'b1;
    req_funct3 = 3'b111; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (mem_read)  begin rd++; if (first_rd == 0) first_rd = c; end
      if (mem_write) begin wr++; if (first_wr == 0) first_wr = c; last_wr_addr = mem_address; end
      if (mem_read && mem_write) bad_strobe = 1'b1;
      if (mem_read || mem_write) begin
        if (addr_seen && mem_address != saddr) bad_strobe = 1'b1;
        saddr = mem_address;
        addr_seen = 1'b1;
      end
      if (req_ready) ready_high = 1'b1;
      if (resp_valid) begin
        lat = c; dat = resp_data; flt = resp_fault;
        break;
      end
    end
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".data"}, dat, exp_data);
    check({tag, ".fault"}, {31'h0, flt}, {31'h0, exp_fault});
    check({tag, ".reads"}, rd, exp_rd);
    check({tag, ".writes"}, wr, exp_wr);
    check({tag, ".strobe_rules"}, {31'h0, bad_strobe}, 32'h0);
    check({tag, ".ready_low_busy"}, {31'h0, ready_high}, 32'h0);
    if (exp_rd > 0 && exp_wr > 0)
      check({tag, ".read_before_write"}, {31'h0, (first_rd < first_wr)}, 32'h1);
    @(negedge clk);
    check({tag, ".resp_one_cycle"}, {31'h0, resp_valid}, 32'h0);
    check({tag, ".ready_after"}, {31'h0, req_ready}, 32'h1);
  endtask

  logic [7:0] rdy_trace, rv_trace;
  logic       seen_bad;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_is_load = 1'b0; req_is_store = 1'b0;
    req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
    pl_en = 1'b0; pl_idx = 6'h0; pl_val = 32'h0; last_wr_addr = 32'h0;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.ready", {31'h0, req_ready}, 32'h1);
    check("reset.flags", {28'h0, resp_valid, resp_fault, mem_read, mem_write}, 32'h0);
    check("reset.resp_data", resp_data, 32'h0);
    check("reset.mem_address", mem_address, 32'h0);
    check("reset.mem_write_data", mem_write_data, 32'h0);
    rst = 1'b1;

    // SW then LW round trip.
    run_req("sw", 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 2, 32'h0, 1'b0, 0, 1);
    check("sw.addr", last_wr_addr, 32'h10);
    check("sw.mem", mem[4], 32'hDEAD_BEEF);
    run_req("lw", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 2, 32'hDEAD_BEEF, 1'b0, 1, 0);

    // Sub-word loads from 0x80FF_7F01 at 0x20.
    preload(6'd8, 32'h80FF_7F01);
    run_req("lb",  1'b1, 1'b0, 3'b000, 32'h23, 32'h0, 2, 32'hFFFF_FF80, 1'b0, 1, 0);
    run_req("lbu", 1'b1, 1'b0, 3'b100, 32'h23, 32'h0, 2, 32'h0000_0080, 1'b0, 1, 0);
    run_req("lh",  1'b1, 1'b0, 3'b001, 32'h20, 32'h0, 2, 32'h0000_7F01, 1'b0, 1, 0);
    run_req("lhu", 1'b1, 1'b0, 3'b101, 32'h22, 32'h0, 2, 32'h0000_80FF, 1'b0, 1, 0);
    run_req("lh_hi", 1'b1, 1'b0, 3'b001, 32'h22, 32'h0, 2, 32'hFFFF_80FF, 1'b0, 1, 0);

    // Sub-word stores as read-modify-write.
    preload(6'd8, 32'h1122_3344);
    run_req("sb", 1'b0, 1'b1, 3'b000, 32'h21, 32'h0000_00AB, 3, 32'h0, 1'b0, 1, 1);
    check("sb.mem", mem[8], 32'h1122_AB44);
    run_req("sh", 1'b0, 1'b1, 3'b001, 32'h22, 32'h1234_CAFE, 3, 32'h0, 1'b0, 1, 1);
    check("sh.mem", mem[8], 32'hCAFE_AB44);

    // Faults: one cycle, no strobes, zero data.
    run_req("f_lw_mis", 1'b1, 1'b0, 3'b010, 32'h02, 32'h0, 1, 32'h0, 1'b1, 0, 0);
    run_req("f_sh_mis", 1'b0, 1'b1, 3'b001, 32'h05, 32'h0, 1, 32'h0, 1'b1, 0, 0);
    run_req("f_ld_f3",  1'b1, 1'b0, 3'b011, 32'h20, 32'h0, 1, 32'h0, 1'b1, 0, 0);
    run_req("f_both",   1'b1, 1'b1, 3'b010, 32'h20, 32'h0, 1, 32'h0, 1'b1, 0, 0);
    run_req("f_none",   1'b0, 1'b0, 3'b010, 32'h20, 32'h0, 1, 32'h0, 1'b1, 0, 0);
    run_req("f_st_f3",  1'b0, 1'b1, 3'b100, 32'h20, 32'h0, 1, 32'h0, 1'b1, 0, 0);
    check("fault.mem_untouched", mem[8], 32'hCAFE_AB44);

    // Back-to-back: req_valid held high across two LW requests.
    @(negedge clk);
    req_valid = 1'b1; req_is_load = 1'b1; req_is_store = 1'b0;
    req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'h0;
    for (int n = 0; n < 8; n++) begin
      if (n > 0) @(negedge clk);
      rdy_trace[n] = req_ready;
      rv_trace[n]  = resp_valid;
      if (n == 4) req_valid = 1'b0;
    end
    check("b2b.ready_trace", {24'h0, rdy_trace}, 32'b1100_1001);
    check("b2b.resp_trace",  {24'h0, rv_trace},  32'b0010_0100);

    // Reset during RMW_RD: no write, no response.
    preload(6'd12, 32'h5566_7788);
    @(negedge clk);
    req_valid = 1'b1; req_is_load = 1'b0; req_is_store = 1'b1;
    req_funct3 = 3'b000; req_addr = 32'h31; req_wdata = 32'h0000_00EE;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rst_mid.in_rmw_rd", {31'h0, mem_read}, 32'h1);
    rst = 1'b0;
    #1;
    check("rst_mid.outputs", {28'h0, mem_read, mem_write, resp_valid, req_ready}, 32'h1);
    seen_bad = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (mem_write || resp_valid) seen_bad = 1'b1;
    end
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (mem_write || resp_valid) seen_bad = 1'b1;
    end
    check("rst_mid.no_write_no_resp", {31'h0, seen_bad}, 32'h0);
    check("rst_mid.mem", mem[12], 32'h5566_7788);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage initiator for the RV32IM pipeline: accepts one load/store request at a time from the MEM stage and drives the word-addressed data memory (`mem_read`, `mem_write`, `address`, `write_data`, `read_data`). Byte and halfword loads are extracted and sign- or zero-extended from the fetched word. Sub-word stores become a read-modify-write sequence, because the data memory has no byte enables. The pipeline is held off through `req_ready` until the response is returned.

## Interface
- `ADDR_WIDTH`, default 32: width of the request and memory address.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst`  input  1: asynchronous, active-low reset; low forces the reset state immediately.
- `req_valid`  input  1: request present.
- `req_ready`  output  1: high only in IDLE; a request is accepted on a cycle where `req_valid && req_ready`.
- `req_is_load`  input  1: load request.
- `req_is_store`  input  1: store request.
- `req_funct3`  input  3: RV32 funct3 code.
  - Loads: LB 000, LH 001, LW 010, LBU 100, LHU 101.
  - Stores: SB 000, SH 001, SW 010.
- `req_addr`  input  ADDR_WIDTH: byte address.
- `req_wdata`  input  32: store data; sub-word data is taken from the low bits.
- `resp_valid`  output  1: one-cycle response pulse.
- `resp_data`  output  32: extended load result; 0 for stores and faults.
- `resp_fault`  output  1: qualifies `resp_valid`; the request was misaligned or illegal.
- `mem_read`  output  1: memory read strobe.
- `mem_write`  output  1: memory write strobe.
- `mem_address`  output  ADDR_WIDTH: word address `{addr[ADDR_WIDTH-1:2], 2'b00}`.
- `mem_write_data`  output  32: word to be written.
- `mem_read_data`  input  32: combinational read word. It is high-Z unless `mem_read` is high and is never sampled otherwise.

## Operation
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
- IDLE, on accept: latch the request fields, then choose the next state:
  - Illegal request → RESP with a fault. Illegal means any of:
    - `req_is_load` and `req_is_store` both high, or both low;
    - load funct3 not in {000,001,010,100,101};
    - store funct3 not in {000,001,010}.
  - Misaligned → RESP with a fault. Misaligned means:
    - halfword access with `addr[0]` = 1;
    - word access with `addr[1:0]` ≠ 00.
  - Legal load → LOAD.
  - SW → STORE.
  - SB or SH → RMW_RD.
- Faulting requests never assert `mem_read` or `mem_write`.
- LOAD:
  - `mem_read` = 1; capture `mem_read_data`.
  - Extract the byte at `addr[1:0]` or the halfword at `addr[1]`.
  - Sign-extend for LB/LH; zero-extend for LBU/LHU; LW passes the word unchanged.
  - Next state: RESP.
- STORE: `mem_write` = 1, `mem_write_data` = `req_wdata`. Next state: RESP.
- RMW_RD: `mem_read` = 1; capture the old word. Next state: RMW_WR.
- RMW_WR:
  - `mem_write` = 1; `mem_write_data` is the old word with the target lane replaced.
  - SB replaces byte lane `addr[1:0]` with `wdata[7:0]`; SH replaces halfword lane `addr[1]` with `wdata[15:0]`. All other bits are unchanged.
  - Next state: RESP.
- RESP: `resp_valid` = 1 for exactly one cycle with the registered `resp_data`/`resp_fault`. Next state: IDLE.
- `mem_read` and `mem_write` are never high in the same cycle.
- `mem_address` is stable for every cycle in which either strobe is high.

## Timing
- Reset values:
  - State = IDLE, so `req_ready` = 1.
  - `resp_valid`, `resp_fault`, `mem_read` and `mem_write` = 0.
  - `resp_data`, `mem_address` and `mem_write_data` = 0.
- Strobes and memory outputs are decoded from registered state and latched fields.
- Latency, counted from the accept edge to the `resp_valid` cycle: load 2 cycles; SW 2; SB/SH 3; fault 1.
- Throughput:
  - `req_ready` is low from the cycle after accept through RESP.
  - The next accept is possible in the cycle after RESP, so at most one request is in flight.
- Request inputs are ignored while `req_ready` = 0.
- Memory writes commit on the rising edge that ends the STORE or RMW_WR cycle.
- Reset mid-operation:
  - All strobes drop immediately and no response is issued.
  - If `rst` falls before the write edge, no partial RMW write occurs.

## Test plan
- Reset with `rst` = 0 held over 3 edges → all outputs 0 and `req_ready` = 1. Release → IDLE.
- SW to 0x0000_0010 with data 0xDEADBEEF, then LW from 0x10:
  - SW: `mem_write` is high for one cycle with `mem_address` = 0x10.
  - LW: `resp_data` = 0xDEADBEEF two cycles after accept.
- Sub-word loads from the word 0x80FF_7F01 at 0x20:
  - LB 0x23 → 0xFFFF_FF80.
  - LBU 0x23 → 0x0000_0080.
  - LH 0x20 → 0x0000_7F01.
  - LHU 0x22 → 0x0000_80FF.
- SB of 0xAB to 0x21 over the word 0x1122_3344 → memory holds 0x1122_AB44. Check the strobe order: read, then write, never together.
- Fault cases, each → `resp_fault` = 1, `resp_data` = 0, strobes never asserted, response 1 cycle after accept:
  - LW at 0x02;
  - SH at 0x05;
  - load funct3 = 011;
  - both type flags high.
- Back-to-back `req_valid` held high → second accept occurs in the cycle after RESP. Also check reset: `rst` low during RMW_RD → no write, and `resp_valid` stays 0.
